// File: rtl/lbp_engine_param_if.sv
// Bus bundle between the LBP engine, the gray pixel memory and the LBP result memory.
// The engine drives the master side; the memories sit on the slave side.
interface lbp_engine_param_if #(
  parameter int ADDR_W = 14,
  parameter int PIX_W  = 8
);
  logic              gray_ready;
  logic              gray_req;
  logic [ADDR_W-1:0] gray_addr;
  logic [PIX_W-1:0]  gray_data;
  logic              lbp_valid;
  logic [ADDR_W-1:0] lbp_addr;
  logic [7:0]        lbp_data;
  logic              finish;

  modport master (
    input  gray_ready, gray_data,
    output gray_req, gray_addr, lbp_valid, lbp_addr, lbp_data, finish
  );

  modport slave (
    output gray_ready, gray_data,
    input  gray_req, gray_addr, lbp_valid, lbp_addr, lbp_data, finish
  );
endinterface

// File: rtl/lbp_engine_param.sv
// Parametrised 3x3 local-binary-pattern engine: streams gray pixels in, writes one code per
// interior centre in raster order, optionally followed by zero codes for every border pixel.
module lbp_engine_param #(
  parameter int IMG_W     = 128,
  parameter int IMG_H     = 128,
  parameter int PIX_W     = 8,
  parameter int ADDR_W    = 14,
  parameter int THRESH    = 0,
  parameter int BORDER_WR = 0
) (
  input  logic                clk,
  input  logic                reset,
  lbp_engine_param_if.master  bus
);
  typedef enum logic [2:0] {IDLE, FETCH, CALC, WRITE, BORDER, DONE} state_t;

  localparam logic [ADDR_W-1:0] W_A      = ADDR_W'(IMG_W);
  localparam logic [ADDR_W-1:0] COL_LAST = ADDR_W'(IMG_W - 2);
  localparam logic [ADDR_W-1:0] ROW_LAST = ADDR_W'(IMG_H - 2);
  localparam logic [ADDR_W-1:0] COL_MAX  = ADDR_W'(IMG_W - 1);
  localparam logic [ADDR_W-1:0] ROW_MAX  = ADDR_W'(IMG_H - 1);
  localparam logic [PIX_W:0]    THR      = (PIX_W + 1)'(THRESH);

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] row_q, row_d, col_q, col_d;
  logic              first_q, first_d;
  logic [3:0]        iss_cnt_q, iss_cnt_d, cap_cnt_q, cap_cnt_d;
  logic [PIX_W-1:0]  win_q [9];
  logic [PIX_W-1:0]  win_d [9];
  logic              gray_req_q, gray_req_d;
  logic [ADDR_W-1:0] gray_addr_q, gray_addr_d;
  logic              lbp_valid_q, lbp_valid_d;
  logic [ADDR_W-1:0] lbp_addr_q, lbp_addr_d;
  logic [7:0]        lbp_data_q, lbp_data_d;
  logic              finish_q, finish_d;

  logic              fetch_go;
  logic [3:0]        issue_idx, cap_slot;
  logic [1:0]        dr, dc;
  logic [ADDR_W-1:0] rd_row, rd_col;
  logic [PIX_W:0]    thr_sum;
  logic [7:0]        code;

  // The sum is one bit wider than a pixel, so a centre+offset past full scale clears every bit.
  assign thr_sum = {1'b0, win_q[4]} + THR;

  for (genvar gi = 0; gi < 8; gi++) begin : g_bit
    localparam int SLOT = (gi < 4) ? gi : gi + 1;
    assign code[gi] = ({1'b0, win_q[SLOT]} >= thr_sum);
  end

  always_comb begin
    state_d     = state_q;
    row_d       = row_q;
    col_d       = col_q;
    first_d     = first_q;
    iss_cnt_d   = iss_cnt_q;
    cap_cnt_d   = cap_cnt_q;
    win_d       = win_q;
    gray_req_d  = 1'b0;
    gray_addr_d = gray_addr_q;
    lbp_valid_d = 1'b0;
    lbp_addr_d  = lbp_addr_q;
    lbp_data_d  = lbp_data_q;
    finish_d    = finish_q;
    fetch_go    = 1'b0;
    issue_idx   = iss_cnt_q;
    cap_slot    = 4'd0;
    dr          = 2'd0;
    dc          = 2'd0;
    rd_row      = '0;
    rd_col      = '0;

    case (state_q)
      IDLE: begin
        if (bus.gray_ready) begin
          state_d   = FETCH;
          row_d     = ADDR_W'(1);
          col_d     = ADDR_W'(1);
          first_d   = 1'b1;
          iss_cnt_d = 4'd0;
          issue_idx = 4'd0;
          fetch_go  = 1'b1;
        end
      end
      FETCH: begin
        if (gray_req_q) begin
          if (first_q) cap_slot = cap_cnt_q;
          else cap_slot = (cap_cnt_q == 4'd0) ? 4'd2 : (cap_cnt_q == 4'd1) ? 4'd5 : 4'd8;
          win_d[cap_slot] = bus.gray_data;
          cap_cnt_d = cap_cnt_q + 4'd1;
          if (cap_cnt_q == (first_q ? 4'd8 : 4'd2)) begin
            state_d   = CALC;
            cap_cnt_d = 4'd0;
          end
        end
        fetch_go = (state_d == FETCH);
      end
      CALC: begin
        lbp_valid_d = 1'b1;
        lbp_data_d  = code;
        lbp_addr_d  = row_q * W_A + col_q;
        state_d     = WRITE;
      end
      WRITE: begin
        if (col_q != COL_LAST) begin
          // Slide the window left; the new right column is fetched next.
          for (int r = 0; r < 3; r++) begin
            win_d[3*r]     = win_q[3*r+1];
            win_d[3*r+1]   = win_q[3*r+2];
          end
          col_d     = col_q + ADDR_W'(1);
          first_d   = 1'b0;
          state_d   = FETCH;
          iss_cnt_d = 4'd0;
          issue_idx = 4'd0;
          fetch_go  = 1'b1;
        end else if (row_q != ROW_LAST) begin
          row_d     = row_q + ADDR_W'(1);
          col_d     = ADDR_W'(1);
          first_d   = 1'b1;
          state_d   = FETCH;
          iss_cnt_d = 4'd0;
          issue_idx = 4'd0;
          fetch_go  = 1'b1;
        end else if (BORDER_WR != 0) begin
          state_d     = BORDER;
          row_d       = '0;
          col_d       = '0;
          lbp_valid_d = 1'b1;
          lbp_addr_d  = '0;
          lbp_data_d  = 8'd0;
        end else begin
          state_d  = DONE;
          finish_d = 1'b1;
        end
      end
      BORDER: begin
        if (row_q == ROW_MAX && col_q == COL_MAX) begin
          state_d  = DONE;
          finish_d = 1'b1;
        end else begin
          // Top/bottom rows are walked in full; middle rows jump from left edge to right edge.
          if (col_q == COL_MAX) begin
            row_d = row_q + ADDR_W'(1);
            col_d = '0;
          end else if (row_q == '0 || row_q == ROW_MAX) begin
            col_d = col_q + ADDR_W'(1);
          end else begin
            col_d = COL_MAX;
          end
          lbp_valid_d = 1'b1;
          lbp_addr_d  = row_d * W_A + col_d;
          lbp_data_d  = 8'd0;
        end
      end
      DONE: begin
        finish_d = 1'b1;
      end
      default: state_d = IDLE;
    endcase

    if (fetch_go && bus.gray_ready && issue_idx < (first_d ? 4'd9 : 4'd3)) begin
      gray_req_d = 1'b1;
      iss_cnt_d  = issue_idx + 4'd1;
      if (first_d) begin
        case (issue_idx)
          4'd0, 4'd1, 4'd2: dr = 2'd0;
          4'd3, 4'd4, 4'd5: dr = 2'd1;
          default:          dr = 2'd2;
        endcase
        dc     = 2'(issue_idx - {1'b0, dr, 1'b0} - {2'b00, dr});
        rd_row = row_d - ADDR_W'(1) + ADDR_W'(dr);
        rd_col = col_d - ADDR_W'(1) + ADDR_W'(dc);
      end else begin
        rd_row = row_d - ADDR_W'(1) + ADDR_W'(issue_idx);
        rd_col = col_d + ADDR_W'(1);
      end
      gray_addr_d = rd_row * W_A + rd_col;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      row_q       <= '0;
      col_q       <= '0;
      first_q     <= 1'b0;
      iss_cnt_q   <= 4'd0;
      cap_cnt_q   <= 4'd0;
      win_q       <= '{default: '0};
      gray_req_q  <= 1'b0;
      gray_addr_q <= '0;
      lbp_valid_q <= 1'b0;
      lbp_addr_q  <= '0;
      lbp_data_q  <= 8'd0;
      finish_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      row_q       <= row_d;
      col_q       <= col_d;
      first_q     <= first_d;
      iss_cnt_q   <= iss_cnt_d;
      cap_cnt_q   <= cap_cnt_d;
      win_q       <= win_d;
      gray_req_q  <= gray_req_d;
      gray_addr_q <= gray_addr_d;
      lbp_valid_q <= lbp_valid_d;
      lbp_addr_q  <= lbp_addr_d;
      lbp_data_q  <= lbp_data_d;
      finish_q    <= finish_d;
    end
  end

  assign bus.gray_req  = gray_req_q;
  assign bus.gray_addr = gray_addr_q;
  assign bus.lbp_valid = lbp_valid_q;
  assign bus.lbp_addr  = lbp_addr_q;
  assign bus.lbp_data  = lbp_data_q;
  assign bus.finish    = finish_q;
endmodule

// File: tb/tb_lbp_engine_param.sv
// Bench for lbp_engine_param: two engine instances (plain 10x7, and 4x4 with offset and border
// write-back) fed from modelled gray memories and checked against a per-pixel LBP reference.
module tb_lbp_engine_param;
  localparam int AW = 10, AH = 7, AAW = 7;
  localparam int BW = 4,  BH = 4, BAW = 4, BTH = 5;
  localparam int LIMIT = 5000;
  localparam int LAT_A = (AH - 2) * (11 + (AW - 3) * 5) + 2;
  localparam int LAT_B = (BH - 2) * (11 + (BW - 3) * 5) + (2 * BW + 2 * (BH - 2)) + 2;

  logic clk = 1'b0;
  logic rst_a_n = 1'b0, rst_b_n = 1'b0;
  always #5 clk = ~clk;

  lbp_engine_param_if #(.ADDR_W(AAW), .PIX_W(8)) bus_a ();
  lbp_engine_param_if #(.ADDR_W(BAW), .PIX_W(8)) bus_b ();

  lbp_engine_param #(.IMG_W(AW), .IMG_H(AH), .PIX_W(8), .ADDR_W(AAW), .THRESH(0), .BORDER_WR(0))
    dut_a (.clk(clk), .reset(rst_a_n), .bus(bus_a));
  lbp_engine_param #(.IMG_W(BW), .IMG_H(BH), .PIX_W(8), .ADDR_W(BAW), .THRESH(BTH), .BORDER_WR(1))
    dut_b (.clk(clk), .reset(rst_b_n), .bus(bus_b));

  int checks = 0, errors = 0;
  int mem_a [AW*AH];
  int mem_b [BW*BH];
  int obs_a [$];
  int obs_b [$];
  int exp_q [$];
  int mode_a = 0, mode_b = 0;
  int viol_a = 0, viol_b = 0;
  logic rdy_edge_a = 1'b0, rdy_edge_b = 1'b0;
  string nm [6] = '{"gray_req", "gray_addr", "lbp_valid", "lbp_addr", "lbp_data", "finish"};

  always @(posedge clk) begin
    rdy_edge_a = bus_a.gray_ready;
    rdy_edge_b = bus_b.gray_ready;
  end

  // Memory models: result writes sampled on the falling edge; read data driven for the next rise.
  always @(negedge clk) begin
    if (bus_a.lbp_valid === 1'b1) obs_a.push_back(int'(bus_a.lbp_addr) * 256 + int'(bus_a.lbp_data));
    if (bus_b.lbp_valid === 1'b1) obs_b.push_back(int'(bus_b.lbp_addr) * 256 + int'(bus_b.lbp_data));
    if (bus_a.gray_req === 1'b1 && rdy_edge_a !== 1'b1) viol_a++;
    if (bus_b.gray_req === 1'b1 && rdy_edge_b !== 1'b1) viol_b++;
    if (bus_a.gray_req === 1'b1 && int'(bus_a.gray_addr) < AW*AH) bus_a.gray_data = 8'(mem_a[bus_a.gray_addr]);
    else bus_a.gray_data = 8'($urandom);
    if (bus_b.gray_req === 1'b1) bus_b.gray_data = 8'(mem_b[bus_b.gray_addr]);
    else bus_b.gray_data = 8'($urandom);
    bus_a.gray_ready = (mode_a == 2) ? ($urandom_range(3, 0) != 0) : (mode_a == 1);
    bus_b.gray_ready = (mode_b == 2) ? ($urandom_range(3, 0) != 0) : (mode_b == 1);
  end

  function automatic int pix(input int sel, input int r, input int c);
    if (sel == 0) return mem_a[r*AW + c];
    return mem_b[r*BW + c];
  endfunction

  function automatic logic fin(input int sel);
    return (sel == 0) ? bus_a.finish : bus_b.finish;
  endfunction

  // Reference: interior codes in raster order, then (B only) zero for each border address.
  function automatic void build_exp(input int sel);
    int w, h, th, code, n, thr;
    w = (sel == 0) ? AW : BW;
    h = (sel == 0) ? AH : BH;
    th = (sel == 0) ? 0 : BTH;
    exp_q.delete();
    for (int r = 1; r < h - 1; r++)
      for (int c = 1; c < w - 1; c++) begin
        thr = pix(sel, r, c) + th;
        code = 0;
        n = 0;
        for (int dy = -1; dy <= 1; dy++)
          for (int dx = -1; dx <= 1; dx++)
            if (dy != 0 || dx != 0) begin
              if (pix(sel, r + dy, c + dx) >= thr) code += (1 << n);
              n++;
            end
        exp_q.push_back((r*w + c) * 256 + code);
      end
    if (sel == 1)
      for (int a = 0; a < w*h; a++)
        if (a/w == 0 || a/w == h-1 || a%w == 0 || a%w == w-1) exp_q.push_back(a * 256);
  endfunction

  task automatic fill(input int sel, input int lo, input int hi);
    if (sel == 0) foreach (mem_a[i]) mem_a[i] = $urandom_range(hi, lo);
    else foreach (mem_b[i]) mem_b[i] = $urandom_range(hi, lo);
  endtask

  task automatic run_frame(input int sel, input int rmode, output int cyc);
    if (sel == 0) begin mode_a = 0; rst_a_n = 1'b0; end
    else begin mode_b = 0; rst_b_n = 1'b0; end
    repeat (2) @(negedge clk);
    if (sel == 0) begin obs_a.delete(); viol_a = 0; rst_a_n = 1'b1; end
    else begin obs_b.delete(); viol_b = 0; rst_b_n = 1'b1; end
    @(posedge clk);
    if (sel == 0) mode_a = rmode; else mode_b = rmode;
    cyc = 0;
    while (fin(sel) !== 1'b1 && cyc < LIMIT) begin
      @(negedge clk);
      #1;
      cyc++;
    end
    checks++;
    if (fin(sel) !== 1'b1) begin
      errors++;
      $display("FAIL frame_timeout dut=%0d: finish=%b after %0d cycles, required 1", sel, fin(sel), cyc);
    end
    $display("frame dut=%0d mode=%0d writes=%0d cycles=%0d", sel, rmode,
             (sel == 0) ? obs_a.size() : obs_b.size(), cyc);
  endtask

  task automatic test_reset();
    logic [15:0] v [6];
    repeat (3) @(negedge clk);
    for (int s = 0; s < 2; s++) begin
      if (s == 0) v = '{16'(bus_a.gray_req), 16'(bus_a.gray_addr), 16'(bus_a.lbp_valid),
                        16'(bus_a.lbp_addr), 16'(bus_a.lbp_data), 16'(bus_a.finish)};
      else        v = '{16'(bus_b.gray_req), 16'(bus_b.gray_addr), 16'(bus_b.lbp_valid),
                        16'(bus_b.lbp_addr), 16'(bus_b.lbp_data), 16'(bus_b.finish)};
      foreach (v[i]) begin
        checks++;
        if (v[i] !== 16'd0) begin
          errors++;
          $display("FAIL reset_%s dut=%0d: got %h, required 0", nm[i], s, v[i]);
        end
      end
    end
  endtask

  // Plain engine: flat, isolated peaks, full-range random, low-range random (many ties).
  task automatic test_images();
    int cyc, g;
    for (int k = 0; k < 5; k++) begin
      case (k)
        0: fill(0, 7, 7);
        1: begin fill(0, 50, 50); mem_a[1*AW + 1] = 60; mem_a[3*AW + 4] = 60; end
        2, 3: fill(0, 0, 255);
        default: fill(0, 0, 3);
      endcase
      build_exp(0);
      run_frame(0, 1, cyc);
      checks++;
      if (cyc !== LAT_A) begin
        errors++;
        $display("FAIL images_latency kind=%0d: %0d cycles, required %0d", k, cyc, LAT_A);
      end
      checks++;
      if (obs_a.size() !== exp_q.size()) begin
        errors++;
        $display("FAIL images_count kind=%0d: got %0d writes, required %0d", k, obs_a.size(), exp_q.size());
      end
      foreach (exp_q[i]) begin
        g = (i < obs_a.size()) ? obs_a[i] : -1;
        checks++;
        if (g !== exp_q[i]) begin
          errors++;
          $display("FAIL images_write kind=%0d idx=%0d: got addr %0d data 0x%02h, required addr %0d data 0x%02h",
                   k, i, g / 256, g % 256, exp_q[i] / 256, exp_q[i] % 256);
        end
      end
    end
    repeat (5) @(negedge clk);
    checks++;
    if (bus_a.finish !== 1'b1 || bus_a.lbp_valid !== 1'b0 || bus_a.gray_req !== 1'b0) begin
      errors++;
      $display("FAIL done_hold: finish=%b lbp_valid=%b gray_req=%b, required 1 0 0",
               bus_a.finish, bus_a.lbp_valid, bus_a.gray_req);
    end
  endtask

  // gray_ready toggled randomly: no request may follow an edge that saw it low.
  task automatic test_stall();
    int cyc, g;
    for (int k = 0; k < 2; k++) begin
      fill(0, 0, 255);
      build_exp(0);
      run_frame(0, 2, cyc);
      checks++;
      if (viol_a !== 0) begin
        errors++;
        $display("FAIL stall_req frame=%0d: %0d requests while not ready, required 0", k, viol_a);
      end
      checks++;
      if (obs_a.size() !== exp_q.size()) begin
        errors++;
        $display("FAIL stall_count frame=%0d: got %0d writes, required %0d", k, obs_a.size(), exp_q.size());
      end
      foreach (exp_q[i]) begin
        g = (i < obs_a.size()) ? obs_a[i] : -1;
        checks++;
        if (g !== exp_q[i]) begin
          errors++;
          $display("FAIL stall_write frame=%0d idx=%0d: got addr %0d data 0x%02h, required addr %0d data 0x%02h",
                   k, i, g / 256, g % 256, exp_q[i] / 256, exp_q[i] % 256);
        end
      end
    end
  endtask

  // Offset engine with border write-back: threshold edges and centre+offset overflow.
  task automatic test_thresh_border();
    int cyc, g;
    for (int k = 0; k < 5; k++) begin
      case (k)
        0: begin fill(1, 104, 104); foreach (mem_b[i]) if (i == 5 || i == 6 || i == 9 || i == 10) mem_b[i] = 100; end
        1: begin fill(1, 105, 105); foreach (mem_b[i]) if (i == 5 || i == 6 || i == 9 || i == 10) mem_b[i] = 100; end
        2: begin fill(1, 255, 255); foreach (mem_b[i]) if (i == 5 || i == 6 || i == 9 || i == 10) mem_b[i] = 252; end
        3: fill(1, 95, 110);
        default: fill(1, 240, 255);
      endcase
      build_exp(1);
      run_frame(1, 1, cyc);
      checks++;
      if (cyc !== LAT_B) begin
        errors++;
        $display("FAIL border_latency kind=%0d: %0d cycles, required %0d", k, cyc, LAT_B);
      end
      checks++;
      if (obs_b.size() !== exp_q.size()) begin
        errors++;
        $display("FAIL border_count kind=%0d: got %0d writes, required %0d", k, obs_b.size(), exp_q.size());
      end
      foreach (exp_q[i]) begin
        g = (i < obs_b.size()) ? obs_b[i] : -1;
        checks++;
        if (g !== exp_q[i]) begin
          errors++;
          $display("FAIL border_write kind=%0d idx=%0d: got addr %0d data 0x%02h, required addr %0d data 0x%02h",
                   k, i, g / 256, g % 256, exp_q[i] / 256, exp_q[i] % 256);
        end
      end
    end
  endtask

  // Reset dropped mid-frame: outputs clear at once, and a fresh run reproduces the reference.
  task automatic test_reset_mid();
    int cyc, g;
    logic [15:0] v [6];
    fill(0, 0, 255);
    build_exp(0);
    rst_a_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_a_n = 1'b1;
    @(posedge clk);
    mode_a = 1;
    repeat ($urandom_range(150, 60)) @(negedge clk);
    @(posedge clk);
    #2 rst_a_n = 1'b0;
    #1;
    v = '{16'(bus_a.gray_req), 16'(bus_a.gray_addr), 16'(bus_a.lbp_valid),
          16'(bus_a.lbp_addr), 16'(bus_a.lbp_data), 16'(bus_a.finish)};
    foreach (v[i]) begin
      checks++;
      if (v[i] !== 16'd0) begin
        errors++;
        $display("FAIL midreset_%s: got %h, required 0", nm[i], v[i]);
      end
    end
    mode_a = 0;
    run_frame(0, 1, cyc);
    checks++;
    if (obs_a.size() !== exp_q.size()) begin
      errors++;
      $display("FAIL midreset_count: got %0d writes, required %0d", obs_a.size(), exp_q.size());
    end
    foreach (exp_q[i]) begin
      g = (i < obs_a.size()) ? obs_a[i] : -1;
      checks++;
      if (g !== exp_q[i]) begin
        errors++;
        $display("FAIL midreset_write idx=%0d: got addr %0d data 0x%02h, required addr %0d data 0x%02h",
                 i, g / 256, g % 256, exp_q[i] / 256, exp_q[i] % 256);
      end
    end
  endtask

  initial begin
    test_reset();
    test_images();
    test_stall();
    test_thresh_border();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog expired");
  end
endmodule
